// File: rtl/rle_pkg.sv
// Shared definitions for the RLE video word format (encoder and rle_video decoder).
// A word is {run_m1, colour}; run_m1 all-ones is reserved for the end-of-frame marker.
package rle_pkg;
    localparam int COLOUR_BITS = 6;
    localparam int RUN_BITS    = 10;
    localparam int WORD_BITS   = COLOUR_BITS + RUN_BITS;

    localparam logic [RUN_BITS-1:0]  MAX_RUN   = '1;
    localparam logic [RUN_BITS-1:0]  RUN_LIMIT = MAX_RUN - 1'b1;
    localparam logic [WORD_BITS-1:0] MARKER    = {{RUN_BITS{1'b1}}, {COLOUR_BITS{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, MARK} rle_state_e;

    function automatic logic [WORD_BITS-1:0] rle_pack(input logic [RUN_BITS-1:0] run_m1,
                                                      input logic [COLOUR_BITS-1:0] colour);
        return {run_m1, colour};
    endfunction

    function automatic logic [RUN_BITS-1:0] rle_run_m1(input logic [WORD_BITS-1:0] word);
        return word[WORD_BITS-1:COLOUR_BITS];
    endfunction

    function automatic logic [COLOUR_BITS-1:0] rle_colour(input logic [WORD_BITS-1:0] word);
        return word[COLOUR_BITS-1:0];
    endfunction
endpackage

// File: rtl/rle_out_stage.sv
// Single-entry valid/ready holding register for RLE words.
// Valid/ready: a word transfers on any clk where word_valid && word_ready; data is held while stalled.
import rle_pkg::*;

module rle_out_stage (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 load,
    input  logic [WORD_BITS-1:0] load_data,
    input  logic                 word_ready,
    output logic                 word_valid,
    output logic [WORD_BITS-1:0] word_data,
    output logic                 slot_free
);
    // Loading while the current word leaves in the same cycle is allowed.
    assign slot_free = !word_valid || word_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_valid <= 1'b0;
            word_data  <= '0;
        end else if (load) begin
            word_valid <= 1'b1;
            word_data  <= load_data;
        end else if (word_ready) begin
            word_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/rle_video_encoder.sv
// Run-length encoder: 6-bit pixels in, 16-bit {run_m1, colour} words out, marker word per frame.
// Pixel handshake: a pixel is taken on any clk where pix_valid && pix_ready.
import rle_pkg::*;

module rle_video_encoder (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic [COLOUR_BITS-1:0] pix_colour,
    input  logic                   pix_last,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [WORD_BITS-1:0]   word_data,
    output logic                   frame_done,
    output rle_state_e             state_dbg
);
    rle_state_e             state, state_n;
    logic [COLOUR_BITS-1:0] cur, cur_n;
    logic [RUN_BITS-1:0]    run_m1, run_n;
    logic                   ready_en;
    logic                   slot_free;
    logic                   load;
    logic [WORD_BITS-1:0]   load_data;
    logic                   accept;

    rle_out_stage u_out (
        .clk        (clk),
        .rstn       (rstn),
        .load       (load),
        .load_data  (load_data),
        .word_ready (word_ready),
        .word_valid (word_valid),
        .word_data  (word_data),
        .slot_free  (slot_free)
    );

    // Holds pix_ready low until the first clock after reset is released.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ready_en <= 1'b0;
        else       ready_en <= 1'b1;
    end

    assign pix_ready  = ready_en && slot_free && (state == IDLE || state == RUN);
    assign accept     = pix_valid && pix_ready;
    assign frame_done = word_valid && word_ready && (word_data == MARKER);
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cur    <= '0;
            run_m1 <= '0;
        end else begin
            state  <= state_n;
            cur    <= cur_n;
            run_m1 <= run_n;
        end
    end

    always_comb begin
        state_n   = state;
        cur_n     = cur;
        run_n     = run_m1;
        load      = 1'b0;
        load_data = rle_pack(run_m1, cur);
        case (state)
            IDLE: if (accept) begin
                cur_n   = pix_colour;
                run_n   = '0;
                state_n = pix_last ? FLUSH : RUN;
            end
            RUN: if (accept) begin
                // Stop one short of all-ones so a data word never aliases the marker.
                if (pix_colour == cur && run_m1 < RUN_LIMIT) begin
                    run_n = run_m1 + 1'b1;
                end else begin
                    load  = 1'b1;
                    cur_n = pix_colour;
                    run_n = '0;
                end
                if (pix_last) state_n = FLUSH;
            end
            FLUSH: if (slot_free) begin
                load    = 1'b1;
                state_n = MARK;
            end
            MARK: if (slot_free) begin
                load      = 1'b1;
                load_data = MARKER;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_rle_video_encoder.sv
// Directed and randomised bench for rle_video_encoder with a run-length golden model.
import rle_pkg::*;

module tb_rle_video_encoder;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [5:0]  pix_colour = 'x;
    logic        pix_last = 1'b0;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic [15:0] word_data;
    logic        frame_done;
    rle_state_e  state_dbg;

    logic [15:0] exp_q[$];
    logic [5:0]  frame[$];
    int          checks = 0;
    int          errors = 0;
    int          run_sum = 0;
    int          frame_dones = 0;
    int          stall_cycles = 0;
    bit          bp_en = 1'b0;
    bit          stall_prev = 1'b0;
    logic [15:0] hold_data;

    rle_video_encoder dut (
        .clk        (clk),
        .rstn       (rstn),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_colour (pix_colour),
        .pix_last   (pix_last),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .frame_done (frame_done),
        .state_dbg  (state_dbg)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Backpressure: inputs change 1 time unit after the active edge
    always @(posedge clk) begin
        #1;
        if (bp_en) word_ready = ($urandom_range(0, 99) >= 30);
    end

    // Scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rstn) begin
            if (stall_prev) begin
                check("hold_valid", 32'(word_valid), 32'd1);
                check("hold_data", 32'(word_data), 32'(hold_data));
            end
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(word_valid), 32'd0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("word", 32'(word_data), 32'(e));
                    check("frame_done", 32'(frame_done), 32'(e == 16'hFFC0));
                    if (e != 16'hFFC0) run_sum += int'(word_data[15:6]) + 1;
                end
            end else if (frame_done !== 1'b0) begin
                check("spurious_frame_done", 32'(frame_done), 32'd0);
            end
            if (frame_done === 1'b1) frame_dones++;
            stall_prev = word_valid && !word_ready;
            hold_data  = word_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Golden model: count identical pixels, cap a run at 1023
    task automatic model_frame();
        logic [5:0] c;
        int cnt;
        c = frame[0];
        cnt = 1;
        for (int i = 1; i < frame.size(); i++) begin
            if (frame[i] == c && cnt < 1023) begin
                cnt++;
            end else begin
                exp_q.push_back({10'(cnt - 1), c});
                c = frame[i];
                cnt = 1;
            end
        end
        exp_q.push_back({10'(cnt - 1), c});
        exp_q.push_back(16'hFFC0);
    endtask

    // Driver tasks: called at posedge+1, return at posedge+1 after acceptance
    task automatic send_pix(input logic [5:0] c, input logic l);
        int waits = 0;
        pix_valid = 1'b1;
        pix_colour = c;
        pix_last = l;
        @(negedge clk);
        while (!pix_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!pix_ready) check("pix_ready_timeout", 32'(pix_ready), 32'd1);
        stall_cycles += waits;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_colour = 'x;
        pix_last = 1'b0;
    endtask

    task automatic send_frame();
        model_frame();
        for (int i = 0; i < frame.size(); i++) send_pix(frame[i], i == frame.size() - 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || word_valid) && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_pulse();
        #2;
        rstn = 1'b0;
        #1;
        check("rst_word_valid", 32'(word_valid), 32'd0);
        check("rst_word_data", 32'(word_data), 32'd0);
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(pix_ready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fd0, low;
        @(posedge clk);
        #1;
        reset_pulse();

        // 1: two runs, marker, one frame_done
        fd0 = frame_dones;
        frame.delete();
        repeat (5) frame.push_back(6'h15);
        repeat (3) frame.push_back(6'h2A);
        send_frame();
        wait_drain();
        check("t1_frame_done_count", 32'(frame_dones - fd0), 32'd1);

        // 2: single pixel frame, pix_ready low for exactly two clocks
        frame.delete();
        frame.push_back(6'h3F);
        model_frame();
        send_pix(6'h3F, 1'b1);
        low = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (pix_ready) break;
            low++;
        end
        check("t2_ready_low", 32'(low), 32'd2);
        @(posedge clk);
        #1;
        wait_drain();

        // 3: run overflow across 2048 identical pixels
        frame.delete();
        repeat (2048) frame.push_back(6'h01);
        send_frame();
        wait_drain();

        // 4: random frame under random backpressure
        run_sum = 0;
        frame.delete();
        while (frame.size() < 640) begin
            logic [5:0] c;
            int rl;
            c = 6'($urandom_range(0, 3));
            rl = $urandom_range(1, 6);
            for (int k = 0; k < rl && frame.size() < 640; k++) frame.push_back(c);
        end
        bp_en = 1'b1;
        send_frame();
        wait_drain();
        bp_en = 1'b0;
        @(posedge clk);
        #1;
        word_ready = 1'b1;
        check("t4_run_sum", 32'(run_sum), 32'd640);

        // 5a: reset in the middle of a run, no words expected
        repeat (100) send_pix(6'h07, 1'b0);
        check("t5_state_run", 32'(state_dbg), 32'(RUN));
        reset_pulse();
        // 5b: reset while stuck in FLUSH
        word_ready = 1'b0;
        repeat (5) send_pix(6'h09, 1'b0);
        send_pix(6'h0A, 1'b1);
        check("t5_state_flush", 32'(state_dbg), 32'(FLUSH));
        check("t5_flush_valid", 32'(word_valid), 32'd1);
        reset_pulse();
        word_ready = 1'b1;
        low = 0;
        repeat (5) begin
            @(negedge clk);
            if (word_valid) low++;
        end
        check("t5_no_marker", 32'(low), 32'd0);
        @(posedge clk);
        #1;
        frame.delete();
        repeat (3) frame.push_back(6'h22);
        frame.push_back(6'h11);
        send_frame();
        wait_drain();

        // 6: alternating colours, no pixel stalls
        stall_cycles = 0;
        frame.delete();
        for (int i = 0; i < 32; i++) frame.push_back(6'(i % 2));
        send_frame();
        check("t6_stalls", 32'(stall_cycles), 32'd0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
